// File: rtl/postbox_pkg.sv
// Shared definitions for the SPI host buffer: byte width, synchroniser depth
// and the transaction classification used while chip select is low.
package postbox_pkg;

  localparam int BYTE_W      = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OUTPUT = 2'd1,
    INPUT  = 2'd2
  } xact_t;

endpackage

// File: rtl/spi_host_buffer_fifo.sv
// spi_byte_fifo: synchronous byte FIFO with first-word fall-through.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO does nothing. data_o reads 0 while empty.
module spi_byte_fifo
  import postbox_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [BYTE_W-1:0]      data_i,
  input  logic                   pop_i,
  output logic [BYTE_W-1:0]      data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array; data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_host_buffer.sv
// spi_host_buffer: oversamples the bridge SPI pins on clock_in, assembles
// LSB-first bytes into an RX FIFO, drives rx_ready flow control and serves one
// host byte on spi_miso for INPUT transactions.
// Optional feature: define SPI_HOST_BUFFER_OVF_COUNT_EN to add the saturating
// ovf_count output counting dropped bytes.
module spi_host_buffer
  import postbox_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int HEADROOM = 2
) (
  input  logic              clock_in,
  input  logic              reset_n_in,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  input  logic              want_tx,
  output logic              spi_miso,
  output logic              rx_ready,
  output logic              tx_pending,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              overflow,
  output logic              frame_err
`ifdef SPI_HOST_BUFFER_OVF_COUNT_EN
  ,
  output logic [7:0]        ovf_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BIT_W = $clog2(BYTE_W);

  // Pin bundle order: {want_tx, mosi, sck, cs}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  pins, synced;
  logic [1:0]                  det_q;              // {sck, cs} one cycle older
  logic cs_s, sck_s, mosi_s, want_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  xact_t xact_q, xact_d;
  logic  rx_bit, tx_step, is_input, byte_done, frame_err_d;

  logic [BIT_W-1:0]  bit_cnt_q;
  // Holds the first seven bits of a byte; the eighth arrives with the edge.
  logic [BYTE_W-2:0] rx_shift_q;
  logic [BYTE_W-1:0] push_data_q, hold_q, tx_shift_q;
  logic              push_q, tx_pending_q, input_done_q, miso_q;
  logic              frame_err_q, overflow_q, rx_ready_q;

  logic [BYTE_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count, free_slots;
  logic              fifo_full, fifo_empty, drop;

  assign pins   = {want_tx, spi_mosi, spi_sck, spi_cs};
  assign synced = sync_q[SYNC_STAGES-1];
  assign cs_s   = synced[0];
  assign sck_s  = synced[1];
  assign mosi_s = synced[2];
  assign want_s = synced[3];

  assign cs_fall  = !cs_s  &&  det_q[0];
  assign cs_rise  =  cs_s  && !det_q[0];
  assign sck_rise =  sck_s && !det_q[1];
  assign sck_fall = !sck_s &&  det_q[1];

  // Synchroniser chain plus edge-detect history. Resetting cs to 0 means a
  // CS that is already low at reset release never looks like a falling edge.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync_q <= '0;
      det_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
      det_q  <= {sck_s, cs_s};
    end
  end

  // Transaction state register.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) xact_q <= IDLE;
    else             xact_q <= xact_d;
  end

  // Classify on CS fall, return to idle on CS rise.
  always_comb begin
    xact_d = xact_q;
    if (cs_fall)      xact_d = (want_s && tx_pending_q) ? INPUT : OUTPUT;
    else if (cs_rise) xact_d = IDLE;
  end

  // Per-state enables for the receive and transmit shifters.
  always_comb begin
    rx_bit   = 1'b0;
    tx_step  = 1'b0;
    is_input = 1'b0;
    case (xact_q)
      OUTPUT: rx_bit = sck_rise;
      INPUT: begin
        rx_bit   = sck_rise;
        tx_step  = sck_fall;
        is_input = 1'b1;
      end
      default: ;
    endcase
  end

  assign byte_done   = rx_bit && (bit_cnt_q == BIT_W'(BYTE_W-1));
  assign frame_err_d = (xact_q != IDLE) && cs_rise && (bit_cnt_q != '0);

  // Shift registers and byte staging; pure data, left unreset.
  always_ff @(posedge clock_in) begin
    if (rx_bit) begin
      rx_shift_q  <= {mosi_s, rx_shift_q[BYTE_W-2:1]};
      push_data_q <= {mosi_s, rx_shift_q};
    end
    if (tx_load && !tx_pending_q) hold_q <= tx_data;
    if (cs_fall && want_s && tx_pending_q) tx_shift_q <= hold_q;
    else if (tx_step)                      tx_shift_q <= {1'b0, tx_shift_q[BYTE_W-1:1]};
  end

  // Framing control: bit counter, push strobe, TX handshake, status flags.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      bit_cnt_q    <= '0;
      push_q       <= 1'b0;
      tx_pending_q <= 1'b0;
      input_done_q <= 1'b0;
      miso_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rx_ready_q   <= 1'b1;
    end else begin
      if (cs_fall || cs_rise) bit_cnt_q <= '0;
      else if (rx_bit)        bit_cnt_q <= bit_cnt_q + 1'b1;

      push_q <= byte_done && !is_input;

      if (cs_fall)                  input_done_q <= 1'b0;
      else if (byte_done && is_input) input_done_q <= 1'b1;

      if (tx_load && !tx_pending_q)                       tx_pending_q <= 1'b1;
      else if (byte_done && is_input && !input_done_q)    tx_pending_q <= 1'b0;

      miso_q      <= is_input ? tx_shift_q[0] : 1'b0;
      frame_err_q <= frame_err_d;
      if (drop) overflow_q <= 1'b1;
      rx_ready_q  <= (free_slots >= CNT_W'(HEADROOM));
    end
  end

  assign drop       = push_q && fifo_full && !rd_ready;
  assign free_slots = CNT_W'(DEPTH) - fifo_count;

  spi_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_in),
    .rst_ni  (reset_n_in),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .pop_i   (rd_ready),
    .data_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign spi_miso   = miso_q;
  assign rx_ready   = rx_ready_q;
  assign tx_pending = tx_pending_q;
  assign rd_data    = fifo_dout;
  assign rd_valid   = !fifo_empty;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

`ifdef SPI_HOST_BUFFER_OVF_COUNT_EN
  logic [7:0] ovf_cnt_q;

  // Dropped-byte counter, saturating at 255.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in)                      ovf_cnt_q <= '0;
    else if (drop && ovf_cnt_q != 8'hFF)  ovf_cnt_q <= ovf_cnt_q + 8'd1;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: doc/spi_host_buffer.md
# spi_host_buffer

Host-side buffer sitting directly downstream of the SPI bridge, between the bridge's SPI master pins and a local parallel consumer (MCU bus or test logic). Oversamples the bridge's SPI signals on a fast local clock, assembles LSB-first bytes into a FIFO, and generates the bridge's `rx_ready` flow control. It also serves one host-supplied byte on `spi_miso` when the target requests input, generating `tx_pending`.

## Interface
Parameters:
- `DEPTH`, 16: RX FIFO depth in bytes; power of two, minimum 4.
- `HEADROOM`, 2: free slots required for `rx_ready` = 1.

Ports:
- `clock_in`  input  1  local clock; must be at least 8× the bridge SPI clock rate.
- `reset_n_in`  input  1  reset, asynchronous, active-low.
- `spi_cs`  input  1  bridge chip select, active-low; asynchronous to `clock_in`.
- `spi_sck`  input  1  bridge SPI clock; asynchronous.
- `spi_mosi`  input  1  bridge data out; asynchronous.
- `want_tx`  input  1  bridge is requesting an input byte; asynchronous.
- `spi_miso`  output  1  data to bridge, LSB first.
- `rx_ready`  output  1  to bridge: room to receive.
- `tx_pending`  output  1  to bridge: host byte loaded and waiting.
- `rd_data`  output  8  FIFO head byte.
- `rd_valid`  output  1  FIFO non-empty.
- `rd_ready`  input  1  consumer pops the head when `rd_valid` && `rd_ready`.
- `tx_data`  input  8  host byte for the next input transaction.
- `tx_load`  input  1  one-cycle strobe; captures `tx_data` if `tx_pending` = 0, otherwise ignored.
- `overflow`  output  1  sticky; a byte was dropped because the FIFO was full. Cleared only by reset.
- `frame_err`  output  1  one-cycle pulse; CS rose with a partial byte.

## Operation
- `spi_cs`, `spi_sck`, `spi_mosi` and `want_tx` each pass through a 2-flop synchroniser, followed by an edge-detect register.
- CS falling edge (synchronised):
  - Bit counter cleared.
  - Transaction classified as INPUT if synchronised `want_tx` = 1 and `tx_pending` = 1; otherwise OUTPUT.
  - INPUT: holding register copied to the TX shift register.
- SCK rising edge while CS low: `spi_mosi` shifted into bit[7] of the RX shift register (shift right); bit counter incremented modulo 8.
- SCK falling edge while CS low, INPUT transaction: TX shift register shifted right. `spi_miso` = TX shift[0] at all times; it is 0 when idle or during an OUTPUT transaction.
- Byte completion (counter wraps 7→0):
  - OUTPUT: byte pushed into the FIFO.
  - INPUT: MOSI byte discarded and `tx_pending` cleared.
  - Further bytes in the same CS window repeat this rule. INPUT clears only once; subsequent bytes shift out 0.
- CS rising edge with counter ≠ 0: partial byte discarded; `frame_err` pulses; `tx_pending` unchanged.
- FIFO full at push:
  - With a simultaneous pop, the push is accepted and the count is unchanged.
  - Otherwise the byte is dropped and `overflow` is set.
- `rx_ready` = (DEPTH − count) ≥ HEADROOM, registered.
- Pop on an empty FIFO: no effect.
- Reset mid-transaction: all state cleared immediately. The rest of the transaction is ignored until the next CS falling edge.

## Timing
- Reset values: `spi_miso` 0, `rx_ready` 1, `tx_pending` 0, `rd_valid` 0, `rd_data` 0, `overflow` 0, `frame_err` 0.
- Pin edge to internal edge event: 3 `clock_in` cycles (2 sync + 1 detect).
- Last SCK rising edge of a byte to `rd_valid` = 1: 4 cycles from an empty FIFO.
- `rx_ready` updates 1 cycle after the count changes.
- `tx_load` accepted: `tx_pending` = 1 on the next cycle.
- `spi_miso` changes 4 cycles after an SCK falling edge. This meets the bridge's sample on the next rising edge provided `clock_in` ≥ 8× SCK.
- `rd_data` is valid in the same cycle as `rd_valid`. First-word fall-through.

## Configuration
- `SPI_HOST_BUFFER_OVF_COUNT_EN` defined:
  - Adds output `ovf_count` [7:0], reset 0.
  - Increments on every dropped byte and saturates at 255.
  - `overflow` behaviour is unchanged.
- Not defined: port absent, no counter logic.

## Structure
- Shared package `postbox_pkg`: `BYTE_W` = 8, `SYNC_STAGES` = 2, and the transaction-type enum `xact_t` {IDLE, OUTPUT, INPUT}.
- One sub-module, `spi_byte_fifo`: synchronous FIFO with first-word fall-through, with `DEPTH` and count output. All SPI framing and TX logic live in the top level.

## Test plan
- OUTPUT transaction of 0xA5, LSB first, with CS low → `rd_data` = 0xA5, `rd_valid` high 4 cycles after the 8th SCK rising edge; `rx_ready` stays 1.
- `tx_load` of 0x3C, then CS falls with `want_tx` = 1, then 8 SCK cycles → `spi_miso` presents bits 0,0,1,1,1,1,0,0; `tx_pending` = 0 after the 8th bit; FIFO is not written.
- DEPTH = 16, 15 bytes sent with no pops → `rx_ready` = 0 after the 15th byte. A 17th byte with no pop → `overflow` = 1, FIFO holds bytes 1–16 (plus `ovf_count` = 1 when the macro is enabled).
- CS rises after 5 bits → `frame_err` pulses once. The next full byte, 0x81, is received correctly.
- FIFO full and a push coinciding with `rd_ready` = 1 → no overflow, count stays 16, order preserved.
- `reset_n_in` asserted after 4 bits of an INPUT transaction → all outputs at reset values. After release, the next OUTPUT byte 0x7E is received intact.
